// File: rtl/mac_pe_os_pkg.sv
// rtl/mac_pe_os_pkg.sv - shared widths, state encoding and defaults for the output-stationary PE
package mac_pe_os_pkg;

    localparam int PE_DATA_W = 3;
    localparam int PE_PROD_W = 6;
    localparam int ACC_W_DEF = 16;
    localparam int CNT_W_DEF = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ACCUM = ST_ACCUM,
        S_DRAIN = ST_DRAIN
    } pe_state_t;

endpackage

// File: rtl/mac_pe_os_mul.sv
// rtl/mac_pe_os_mul.sv - 3x3 unsigned array multiplier, purely combinational
module mac_pe_os_mul
    import mac_pe_os_pkg::*;
(
    input  logic [PE_DATA_W-1:0] i_a,
    input  logic [PE_DATA_W-1:0] i_b,
    output logic [PE_PROD_W-1:0] o_p
);

    logic [PE_PROD_W-1:0] w_pp0;
    logic [PE_PROD_W-1:0] w_pp1;
    logic [PE_PROD_W-1:0] w_pp2;

    // One AND row per multiplier bit, shifted into place and summed
    assign w_pp0 = {3'b000, i_a & {PE_DATA_W{i_b[0]}}};
    assign w_pp1 = {2'b00, i_a & {PE_DATA_W{i_b[1]}}, 1'b0};
    assign w_pp2 = {1'b0, i_a & {PE_DATA_W{i_b[2]}}, 2'b00};
    assign o_p   = w_pp0 + w_pp1 + w_pp2;

endmodule

// File: rtl/mac_pe_os.sv
// rtl/mac_pe_os.sv - output-stationary systolic MAC PE with saturating accumulator and drain chain
module mac_pe_os
    import mac_pe_os_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PE_DATA_W-1:0] a_in,
    input  logic                 a_valid_in,
    input  logic [PE_DATA_W-1:0] b_in,
    input  logic                 b_valid_in,
    output logic [PE_DATA_W-1:0] a_out,
    output logic                 a_valid_out,
    output logic [PE_DATA_W-1:0] b_out,
    output logic                 b_valid_out,
    input  logic                 clear,
    input  logic                 drain,
    input  logic [ACC_W-1:0]     acc_chain_in,
    input  logic                 acc_chain_vin,
    output logic [ACC_W-1:0]     acc_out,
    output logic                 acc_vout,
    output logic [CNT_W-1:0]     mac_count,
    output logic                 overflow,
    output logic                 busy
);

    pe_state_t            r_state;
    logic [ACC_W-1:0]     r_acc;
    logic [ACC_W-1:0]     r_acc_out;
    logic                 r_acc_vout;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_ovf;
    logic [PE_DATA_W-1:0] r_a;
    logic [PE_DATA_W-1:0] r_b;
    logic                 r_a_v;
    logic                 r_b_v;

    logic [PE_PROD_W-1:0] w_prod;
    logic [ACC_W:0]       w_sum;
    logic                 w_mac;

    mac_pe_os_mul u_mul (
        .i_a (a_in),
        .i_b (b_in),
        .o_p (w_prod)
    );

    // Extra MSB of the sum is the saturation flag
    assign w_sum = {1'b0, r_acc} + {{(ACC_W + 1 - PE_PROD_W){1'b0}}, w_prod};
    assign w_mac = (r_state == S_ACCUM) && a_valid_in && b_valid_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_acc_out  <= '0;
            r_acc_vout <= 1'b0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_a_v      <= 1'b0;
            r_b_v      <= 1'b0;
        end else begin
            r_a   <= a_in;
            r_b   <= b_in;
            r_a_v <= a_valid_in;
            r_b_v <= b_valid_in;
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    r_acc_vout <= 1'b0;
                    if (drain) begin
                        r_state    <= S_DRAIN;
                        r_acc_out  <= r_acc;
                        r_acc_vout <= 1'b1;
                    end else if (clear) begin
                        r_state <= S_ACCUM;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                    end else if (w_mac) begin
                        if (w_sum[ACC_W]) begin
                            r_acc <= '1;
                            r_ovf <= 1'b1;
                        end else begin
                            r_acc <= w_sum[ACC_W-1:0];
                        end
                        if (!(&r_cnt)) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    r_acc_out  <= acc_chain_in;
                    r_acc_vout <= acc_chain_vin;
                    if (!acc_chain_vin) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_acc_vout <= 1'b0;
                end
            endcase
        end
    end

    assign a_out       = r_a;
    assign a_valid_out = r_a_v;
    assign b_out       = r_b;
    assign b_valid_out = r_b_v;
    assign acc_out     = r_acc_out;
    assign acc_vout    = r_acc_vout;
    assign mac_count   = r_cnt;
    assign overflow    = r_ovf;
    assign busy        = (r_state == S_DRAIN);

endmodule

// File: tb/tb_mac_pe_os.sv
// tb/tb_mac_pe_os.sv - self-checking bench for mac_pe_os at ACC_W=16 and ACC_W=8
module tb_mac_pe_os;

    logic        clk;
    logic        rst;
    logic [2:0]  a_in;
    logic        a_valid_in;
    logic [2:0]  b_in;
    logic        b_valid_in;
    logic        clear;
    logic        drain;
    logic [15:0] chain16;
    logic [7:0]  chain8;
    logic        chain_v;

    logic [2:0]  a_out16, b_out16, a_out8, b_out8;
    logic        av16, bv16, av8, bv8;
    logic [15:0] acc_out16;
    logic [7:0]  acc_out8;
    logic        vout16, vout8, ovf16, ovf8, busy16, busy8;
    logic [7:0]  cnt16, cnt8;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: accumulated value per width, tracked with plain arithmetic
    longint m_acc16, m_acc8;
    int     m_cnt;
    bit     m_ovf16, m_ovf8;

    mac_pe_os #(.ACC_W(16), .CNT_W(8)) dut16 (
        .clk(clk), .rst(rst),
        .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in), .b_valid_in(b_valid_in),
        .a_out(a_out16), .a_valid_out(av16), .b_out(b_out16), .b_valid_out(bv16),
        .clear(clear), .drain(drain),
        .acc_chain_in(chain16), .acc_chain_vin(chain_v),
        .acc_out(acc_out16), .acc_vout(vout16),
        .mac_count(cnt16), .overflow(ovf16), .busy(busy16)
    );

    mac_pe_os #(.ACC_W(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst),
        .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in), .b_valid_in(b_valid_in),
        .a_out(a_out8), .a_valid_out(av8), .b_out(b_out8), .b_valid_out(bv8),
        .clear(clear), .drain(drain),
        .acc_chain_in(chain8), .acc_chain_vin(chain_v),
        .acc_out(acc_out8), .acc_vout(vout8),
        .mac_count(cnt8), .overflow(ovf8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_in = 0; b_in = 0; a_valid_in = 0; b_valid_in = 0;
        clear = 0; drain = 0; chain16 = 0; chain8 = 0; chain_v = 0;
    endtask

    task automatic do_clear();
        idle_inputs();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_acc16 = 0; m_acc8 = 0; m_cnt = 0; m_ovf16 = 0; m_ovf8 = 0;
    endtask

    // Applies one operand pair while accumulating and checks forwarding and count
    task automatic mac_pair(input int a, input int b, input bit va, input bit vb, input string tag);
        a_in = 3'(a); b_in = 3'(b); a_valid_in = va; b_valid_in = vb;
        tick();
        if (va && vb) begin
            m_acc16 = m_acc16 + a * b;
            if (m_acc16 > 65535) begin m_acc16 = 65535; m_ovf16 = 1; end
            m_acc8 = m_acc8 + a * b;
            if (m_acc8 > 255) begin m_acc8 = 255; m_ovf8 = 1; end
            if (m_cnt < 255) m_cnt++;
        end
        chk({tag, "_a_out"}, 32'(a_out16), 32'(a));
        chk({tag, "_b_out"}, 32'(b_out8), 32'(b));
        chk({tag, "_av"}, 32'(av16), 32'(va));
        chk({tag, "_bv"}, 32'(bv8), 32'(vb));
        chk({tag, "_cnt"}, 32'(cnt16), 32'(m_cnt));
        a_valid_in = 0; b_valid_in = 0;
    endtask

    // Drains with an empty chain and checks both accumulators against the model
    task automatic drain_check(input string tag);
        idle_inputs();
        drain = 1'b1;
        tick();
        drain = 1'b0;
        chk({tag, "_acc16"}, 32'(acc_out16), 32'(m_acc16));
        chk({tag, "_acc8"}, 32'(acc_out8), 32'(m_acc8));
        chk({tag, "_vout"}, 32'(vout16), 32'd1);
        chk({tag, "_busy"}, 32'(busy8), 32'd1);
        chk({tag, "_ovf16"}, 32'(ovf16), 32'(m_ovf16));
        chk({tag, "_ovf8"}, 32'(ovf8), 32'(m_ovf8));
        chk({tag, "_cnt8"}, 32'(cnt8), 32'(m_cnt));
        tick();
        chk({tag, "_exit_vout"}, 32'(vout16), 32'd0);
        chk({tag, "_exit_busy"}, 32'(busy16), 32'd0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        m_acc16 = 0; m_acc8 = 0; m_cnt = 0; m_ovf16 = 0; m_ovf8 = 0;
        tick();
        tick();
        chk("rst_a_out", 32'(a_out16), 32'd0);
        chk("rst_av", 32'(av8), 32'd0);
        chk("rst_acc_out", 32'(acc_out16), 32'd0);
        chk("rst_vout", 32'(vout8), 32'd0);
        chk("rst_cnt", 32'(cnt16), 32'd0);
        chk("rst_ovf", 32'(ovf8), 32'd0);
        chk("rst_busy", 32'(busy16), 32'd0);
        rst = 1'b0;

        // (7,7) x3 -> 147
        do_clear();
        for (int i = 0; i < 3; i++) mac_pair(7, 7, 1, 1, "t1");
        drain_check("t1");

        // (7,7) x6 -> 294, saturates at 255 in the 8-bit instance
        do_clear();
        for (int i = 0; i < 6; i++) mac_pair(7, 7, 1, 1, "t2");
        drain_check("t2");

        // Pair in IDLE is forwarded only
        idle_inputs();
        a_in = 3; b_in = 2; a_valid_in = 1; b_valid_in = 1;
        tick();
        chk("t5_a_out", 32'(a_out16), 32'd3);
        chk("t5_b_out", 32'(b_out16), 32'd2);
        chk("t5_cnt", 32'(cnt16), 32'd6);
        drain_check("t5");

        // acc = 20, chain feeds 5 then 9 then ends
        do_clear();
        mac_pair(4, 5, 1, 1, "t3");
        idle_inputs();
        drain = 1'b1;
        tick();
        drain = 1'b0;
        chk("t3_acc", 32'(acc_out16), 32'd20);
        chk("t3_v0", 32'(vout16), 32'd1);
        chain16 = 5; chain8 = 5; chain_v = 1; drain = 1'b1;
        tick();
        drain = 1'b0;
        chk("t3_c5", 32'(acc_out16), 32'd5);
        chk("t3_c5_8", 32'(acc_out8), 32'd5);
        chk("t3_v1", 32'(vout16), 32'd1);
        chain16 = 9; chain8 = 9;
        tick();
        chk("t3_c9", 32'(acc_out16), 32'd9);
        chk("t3_busy", 32'(busy16), 32'd1);
        chain_v = 0; chain16 = 77;
        tick();
        chk("t3_end_v", 32'(vout16), 32'd0);
        chk("t3_end_busy", 32'(busy16), 32'd0);
        idle_inputs();
        tick();
        chk("t3_idle_v", 32'(vout16), 32'd0);

        // clear with drain: drain wins, count survives
        do_clear();
        mac_pair(3, 4, 1, 1, "t4");
        idle_inputs();
        clear = 1'b1; drain = 1'b1;
        tick();
        idle_inputs();
        chk("t4_acc", 32'(acc_out16), 32'd12);
        chk("t4_v", 32'(vout16), 32'd1);
        chk("t4_busy", 32'(busy16), 32'd1);
        chk("t4_cnt", 32'(cnt16), 32'd1);
        tick();
        chk("t4_exit", 32'(busy8), 32'd0);
        drain_check("t4b");

        // Randomized accumulation rounds
        for (int r = 0; r < 4; r++) begin
            do_clear();
            for (int i = 0; i < 40; i++) begin
                mac_pair(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                         $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, "rnd");
            end
            drain_check("rnd");
        end

        // rst on the second DRAIN cycle aborts the chain
        do_clear();
        mac_pair(2, 3, 1, 1, "t6");
        idle_inputs();
        drain = 1'b1;
        tick();
        drain = 1'b0;
        chk("t6_first", 32'(acc_out16), 32'd6);
        chain16 = 11; chain8 = 11; chain_v = 1; rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        chk("t6_vout", 32'(vout16), 32'd0);
        chk("t6_busy", 32'(busy16), 32'd0);
        chk("t6_cnt", 32'(cnt16), 32'd0);
        m_acc16 = 0; m_acc8 = 0; m_cnt = 0; m_ovf16 = 0; m_ovf8 = 0;
        drain_check("t6_acc");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
